// File: rtl/pipeline_hazard_controller.sv
// rtl/pipeline_hazard_controller.sv - hazard, forwarding and memory-wait sequencing for a 5-stage pipeline
//
// Purpose: per-stage stall/flush enables, execute-stage forwarding selects,
// memory-stage freeze with timeout error, saturating stall/flush counters.
// Ports:
//   clk, rst                        clock, asynchronous active-high reset
//   Rs1D/Rs2D/Rs1E/Rs2E/RdE/RdM/RdW register addresses per stage
//   MemReadEnE, PCSrcD, JalD        load-use and redirect sources
//   RegWriteEnM/W, MemReadEnM,
//   MemWriteEnM, MemReadyM          forwarding sources and memory handshake
//   StallF/D/E/M, FlushD/E/W        pipeline register controls
//   ForwardAE/BE                    00 regfile, 01 writeback, 10 memory ALU
//   MemErr                          sticky memory timeout error
//   StallCount, FlushCount          saturating performance counters
module pipeline_hazard_controller #(
  parameter int XLEN        = 64,
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       Rs1D,
  input  logic [4:0]       Rs2D,
  input  logic [4:0]       Rs1E,
  input  logic [4:0]       Rs2E,
  input  logic [4:0]       RdE,
  input  logic             MemReadEnE,
  input  logic             PCSrcD,
  input  logic             JalD,
  input  logic [4:0]       RdM,
  input  logic             RegWriteEnM,
  input  logic             MemReadEnM,
  input  logic             MemWriteEnM,
  input  logic             MemReadyM,
  input  logic [4:0]       RdW,
  input  logic             RegWriteEnW,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             StallM,
  output logic             FlushD,
  output logic             FlushE,
  output logic             FlushW,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             MemErr,
  output logic [CNT_W-1:0] StallCount,
  output logic [CNT_W-1:0] FlushCount
);

  localparam logic [1:0] RUN      = 2'd0;
  localparam logic [1:0] MEM_WAIT = 2'd1;
  localparam logic [1:0] MEM_ERR  = 2'd2;

  localparam logic [7:0] TIMEOUT = 8'(MEM_TIMEOUT);

  // Only register addresses are compared; the datapath width is carried for
  // documentation and sanity-checked here together with the timeout range.
  if (XLEN < 1 || MEM_TIMEOUT < 1 || MEM_TIMEOUT > 255) begin : g_param_chk
    $error("pipeline_hazard_controller: illegal XLEN or MEM_TIMEOUT");
  end

  logic [1:0]       state_q, state_d;
  logic [7:0]       wcnt_q, wcnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic memreq, lu, redir;
  logic freeze, run_eval;

  assign memreq = MemReadEnM | MemWriteEnM;
  assign lu     = MemReadEnE & (RdE != 5'd0) & ((RdE == Rs1D) | (RdE == Rs2D));
  assign redir  = PCSrcD | JalD;

  always_comb begin
    state_d  = state_q;
    wcnt_d   = wcnt_q;
    freeze   = 1'b0;
    run_eval = 1'b0;
    case (state_q)
      RUN: begin
        if (memreq && !MemReadyM) begin
          // The first unanswered cycle already counts as wait cycle 1.
          freeze  = 1'b1;
          wcnt_d  = 8'd1;
          state_d = (TIMEOUT == 8'd1) ? MEM_ERR : MEM_WAIT;
        end else begin
          run_eval = 1'b1;
        end
      end
      MEM_WAIT: begin
        if (MemReadyM) begin
          // Ack releases the freeze in the same cycle; normal hazard logic applies.
          run_eval = 1'b1;
          wcnt_d   = 8'd0;
          state_d  = RUN;
        end else begin
          freeze = 1'b1;
          wcnt_d = wcnt_q + 8'd1;
          if (wcnt_d >= TIMEOUT) state_d = MEM_ERR;
        end
      end
      MEM_ERR: freeze = 1'b1;
      default: begin
        state_d = RUN;
        wcnt_d  = 8'd0;
      end
    endcase
  end

  // Memory freeze outranks load-use, which in turn suppresses a redirect
  // whose branch operands are not yet available.
  always_comb begin
    StallF    = 1'b0;
    StallD    = 1'b0;
    StallE    = 1'b0;
    StallM    = 1'b0;
    FlushD    = 1'b0;
    FlushE    = 1'b0;
    FlushW    = 1'b0;
    ForwardAE = 2'b00;
    ForwardBE = 2'b00;
    if (!rst) begin
      StallF = freeze | (run_eval & lu);
      StallD = freeze | (run_eval & lu);
      StallE = freeze;
      StallM = freeze;
      FlushW = freeze;
      FlushE = run_eval & lu;
      FlushD = run_eval & !lu & redir;
      if (RegWriteEnM && RdM != 5'd0 && RdM == Rs1E)      ForwardAE = 2'b10;
      else if (RegWriteEnW && RdW != 5'd0 && RdW == Rs1E) ForwardAE = 2'b01;
      if (RegWriteEnM && RdM != 5'd0 && RdM == Rs2E)      ForwardBE = 2'b10;
      else if (RegWriteEnW && RdW != 5'd0 && RdW == Rs2E) ForwardBE = 2'b01;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (StallF && stall_cnt_q != '1)              stall_cnt_d = stall_cnt_q + 1'b1;
    if ((FlushD || FlushE) && flush_cnt_q != '1)  flush_cnt_d = flush_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= RUN;
      wcnt_q      <= 8'd0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wcnt_q      <= wcnt_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign MemErr     = (state_q == MEM_ERR);
  assign StallCount = stall_cnt_q;
  assign FlushCount = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// tb/tb_pipeline_hazard_controller.sv - scoreboard bench for pipeline_hazard_controller
module tb_pipeline_hazard_controller;

  localparam int CNT_W = 4;

  // {StallF,StallD,StallE,StallM, FlushD,FlushE,FlushW, ForwardAE, ForwardBE, MemErr}
  localparam logic [11:0] C_IDLE = 12'b0000_000_00_00_0;
  localparam logic [11:0] C_LU   = 12'b1100_010_00_00_0;
  localparam logic [11:0] C_BR   = 12'b0000_100_00_00_0;
  localparam logic [11:0] C_FRZ  = 12'b1111_001_00_00_0;
  localparam logic [11:0] C_ERR  = 12'b1111_001_00_00_1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic MemReadEnE, PCSrcD, JalD, RegWriteEnM, MemReadEnM, MemWriteEnM, MemReadyM, RegWriteEnW;
  logic StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, MemErr;
  logic [1:0] ForwardAE, ForwardBE;
  logic [CNT_W-1:0] StallCount, FlushCount;

  pipeline_hazard_controller #(.XLEN(64), .MEM_TIMEOUT(4), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
    .MemReadEnE(MemReadEnE), .PCSrcD(PCSrcD), .JalD(JalD),
    .RdM(RdM), .RegWriteEnM(RegWriteEnM), .MemReadEnM(MemReadEnM),
    .MemWriteEnM(MemWriteEnM), .MemReadyM(MemReadyM),
    .RdW(RdW), .RegWriteEnW(RegWriteEnW),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
    .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .MemErr(MemErr),
    .StallCount(StallCount), .FlushCount(FlushCount)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       nm;
    int          kind;   // 0 control bundle, 1 StallCount, 2 FlushCount
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad   = 0;

  // Monitor: outputs are sampled on the falling edge, mid-cycle.
  exp_t        it;
  logic [31:0] act;
  always @(negedge clk) begin
    while (sb.size() > 0) begin
      it = sb.pop_front();
      case (it.kind)
        0:       act = {20'd0, StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW,
                        ForwardAE, ForwardBE, MemErr};
        1:       act = 32'(StallCount);
        default: act = 32'(FlushCount);
      endcase
      total++;
      if (act !== it.exp) begin
        bad++;
        $display("FAIL %s: got 0x%0h expected 0x%0h", it.nm, act, it.exp);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    {Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW} = '0;
    {MemReadEnE, PCSrcD, JalD, RegWriteEnM, MemReadEnM, MemWriteEnM, MemReadyM, RegWriteEnW} = '0;
  endtask

  task automatic exp_c(input string nm, input logic [11:0] e);
    sb.push_back('{nm, 0, {20'd0, e}});
  endtask

  task automatic exp_s(input string nm, input int v);
    sb.push_back('{nm, 1, 32'(v)});
  endtask

  task automatic exp_f(input string nm, input int v);
    sb.push_back('{nm, 2, 32'(v)});
  endtask

  task automatic set_lu();
    MemReadEnE = 1'b1; RdE = 5'd5; Rs1D = 5'd5;
  endtask

  task automatic do_reset(input string nm);
    tick();
    rst = 1'b1;
    clear_in();
    exp_c({nm, "_ctl"}, C_IDLE);
    exp_s({nm, "_scnt"}, 0);
    exp_f({nm, "_fcnt"}, 0);
    tick();
    rst = 1'b0;
  endtask

  initial begin
    clear_in();
    // Outputs forced low during reset even with hazard-causing inputs.
    tick();
    set_lu(); PCSrcD = 1'b1; RegWriteEnM = 1'b1; RdM = 5'd7; Rs1E = 5'd7;
    exp_c("rst_ctl", C_IDLE); exp_s("rst_scnt", 0); exp_f("rst_fcnt", 0);
    tick(); rst = 1'b0; clear_in();

    // Load-use: one cycle of stall + bubble, then RdE=0 never stalls.
    tick(); set_lu(); exp_c("lu", C_LU);
    tick(); clear_in(); exp_c("lu_after", C_IDLE); exp_s("lu_scnt", 1); exp_f("lu_fcnt", 1);
    tick(); MemReadEnE = 1'b1; exp_c("lu_rd0", C_IDLE);
    tick(); MemReadEnE = 1'b1; RdE = 5'd3; Rs2D = 5'd3; exp_c("lu_rs2", C_LU);
    do_reset("r1");

    // Branch vs load-use, then jump.
    tick(); MemReadEnE = 1'b1; RdE = 5'd3; Rs2D = 5'd3; PCSrcD = 1'b1; exp_c("br_lu", C_LU);
    tick(); clear_in(); PCSrcD = 1'b1; exp_c("br", C_BR); exp_f("br_fcnt1", 1);
    tick(); clear_in(); JalD = 1'b1; exp_c("jal", C_BR); exp_f("br_fcnt2", 2);
    tick(); clear_in(); exp_c("br_idle", C_IDLE); exp_f("br_fcnt3", 3); exp_s("br_scnt", 1);
    do_reset("r2");

    // Memory wait of 3 cycles; ack cycle evaluates load-use normally.
    for (int i = 0; i < 3; i++) begin
      tick(); clear_in(); MemReadEnM = 1'b1; exp_c($sformatf("mw_frz%0d", i), C_FRZ);
    end
    tick(); MemReadyM = 1'b1; set_lu(); exp_c("mw_ack_lu", C_LU); exp_s("mw_scnt3", 3);
    tick(); clear_in(); MemWriteEnM = 1'b1; MemReadyM = 1'b1;
    exp_c("mw_run", C_IDLE); exp_s("mw_scnt4", 4); exp_f("mw_fcnt", 1);
    do_reset("r3");

    // Timeout with MEM_TIMEOUT=4.
    for (int i = 0; i < 4; i++) begin
      tick(); clear_in(); MemReadEnM = 1'b1; exp_c($sformatf("to_frz%0d", i), C_FRZ);
    end
    tick(); exp_c("to_err", C_ERR);
    tick(); MemReadyM = 1'b1; exp_c("to_err_rdy", C_ERR);
    tick(); clear_in(); MemReadyM = 1'b1; exp_c("to_err_idle", C_ERR); exp_s("to_scnt", 6);
    do_reset("r4");
    tick(); MemReadEnM = 1'b1; MemReadyM = 1'b1; exp_c("to_cleared", C_IDLE);

    // Reset while in MEM_WAIT.
    tick(); clear_in(); MemReadEnM = 1'b1; exp_c("mwr_frz0", C_FRZ);
    tick(); exp_c("mwr_frz1", C_FRZ);
    do_reset("r5");
    tick(); MemReadEnM = 1'b1; MemReadyM = 1'b1; exp_c("mwr_run", C_IDLE);

    // Forwarding priority.
    tick(); clear_in(); RdM = 5'd7; RdW = 5'd7; Rs1E = 5'd7; RegWriteEnM = 1'b1; RegWriteEnW = 1'b1;
    exp_c("fwd_a_mem", 12'b0000_000_10_00_0);
    tick(); RegWriteEnM = 1'b0; exp_c("fwd_a_wb", 12'b0000_000_01_00_0);
    tick(); clear_in(); RdW = 5'd0; Rs2E = 5'd0; RegWriteEnW = 1'b1; exp_c("fwd_b_x0", C_IDLE);
    tick(); clear_in(); RdM = 5'd9; RdW = 5'd9; Rs2E = 5'd9; RegWriteEnM = 1'b1; RegWriteEnW = 1'b1;
    exp_c("fwd_b_mem", 12'b0000_000_00_10_0);
    tick(); clear_in(); RdW = 5'd4; Rs2E = 5'd4; Rs1E = 5'd4; RegWriteEnW = 1'b1;
    exp_c("fwd_ab_wb", 12'b0000_000_01_01_0);

    // Counter saturation at 4 bits.
    do_reset("r6");
    for (int i = 0; i < 20; i++) begin
      tick(); clear_in(); set_lu();
    end
    tick(); clear_in(); exp_s("sat_scnt", 15); exp_f("sat_fcnt", 15);

    @(negedge clk);
    #1;
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL sb_drain: got %0d pending expected 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
